// File: rtl/nlfsr_pkg.sv
// Shared types and constants for the NLFSR tap-search front end.
package nlfsr_pkg;

    localparam int COEF_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        LOAD,
        RUN,
        NEXT,
        DONE
    } state_t;

    function automatic int max_tap(input int bytes);
        return bytes * 8 - 1;
    endfunction

endpackage

// File: rtl/nlfsr_tap_feeder_if.sv
// Coefficient/verdict link between the tap feeder and the NLFSR core.
interface nlfsr_tap_feeder_if;
    import nlfsr_pkg::*;

    logic              ready;
    logic              failure;
    logic              found;
    logic              ena;
    logic              take_coef;
    logic [COEF_W-1:0] coef;

    modport master (
        input  ready, failure, found,
        output ena, take_coef, coef
    );

    modport slave (
        output ready, failure, found,
        input  ena, take_coef, coef
    );

endinterface

// File: rtl/nlfsr_comb_next.sv
// Lexicographic successor of a strictly increasing tap combination.
module nlfsr_comb_next
    import nlfsr_pkg::*;
#(
    parameter int BYTES       = 4,
    parameter int NUM_OF_TAPS = 2
) (
    input  logic [NUM_OF_TAPS-1:0][COEF_W-1:0] taps,
    output logic [NUM_OF_TAPS-1:0][COEF_W-1:0] taps_next,
    output logic                               exhausted
);

    localparam int MAX_TAP = max_tap(BYTES);

    logic        have_pivot;
    int unsigned pivot;

    always_comb begin
        have_pivot = 1'b0;
        pivot      = 0;
        taps_next  = taps;
        // Rightmost position still below its ceiling MAX_TAP-(N-1-i)
        for (int unsigned i = 0; i < NUM_OF_TAPS; i++) begin
            if (taps[i] < COEF_W'(MAX_TAP - NUM_OF_TAPS + 1 + int'(i))) begin
                have_pivot = 1'b1;
                pivot      = i;
            end
        end
        for (int unsigned j = 0; j < NUM_OF_TAPS; j++) begin
            if (j == pivot) begin
                taps_next[j] = taps[j] + 1'b1;
            end else if (j > pivot) begin
                taps_next[j] = taps_next[j-1] + 1'b1;
            end
        end
        exhausted = !have_pivot;
    end

endmodule

// File: rtl/nlfsr_tap_feeder.sv
// Enumerates tap combinations, feeds them to the NLFSR byte by byte and
// tallies the found/failure verdicts, with a watchdog on missing verdicts.
module nlfsr_tap_feeder
    import nlfsr_pkg::*;
#(
    parameter int BYTES       = 4,
    parameter int NUM_OF_TAPS = 2,
    parameter int TIMEOUT_CYC = 4096,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          res,
    input  logic                          start,
    nlfsr_tap_feeder_if.master            nlfsr,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout_err,
    output logic [CNT_W-1:0]              found_cnt,
    output logic [CNT_W-1:0]              cand_cnt,
    output logic [NUM_OF_TAPS*COEF_W-1:0] last_found
);

    localparam int K_W  = (NUM_OF_TAPS > 1) ? $clog2(NUM_OF_TAPS) : 1;
    localparam int WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef logic [NUM_OF_TAPS-1:0][COEF_W-1:0] tap_vec_t;

    state_t            state, state_next;
    tap_vec_t          taps, taps_next;
    logic              exhausted;
    logic [K_W-1:0]    k;
    logic [WD_W-1:0]   wd;
    logic              wd_hit;
    logic              ena_c, take_coef_c;
    logic [COEF_W-1:0] coef_c;

    function automatic tap_vec_t first_taps();
        first_taps = '0;
        for (int unsigned i = 0; i < NUM_OF_TAPS; i++) begin
            first_taps[i] = COEF_W'(i + 1);
        end
    endfunction

    // tap[0] lands in the most significant byte
    function automatic logic [NUM_OF_TAPS*COEF_W-1:0] pack_taps(input tap_vec_t t);
        pack_taps = '0;
        for (int unsigned i = 0; i < NUM_OF_TAPS; i++) begin
            pack_taps[(NUM_OF_TAPS-1-i)*COEF_W +: COEF_W] = t[i];
        end
    endfunction

    nlfsr_comb_next #(
        .BYTES       (BYTES),
        .NUM_OF_TAPS (NUM_OF_TAPS)
    ) u_comb_next (
        .taps      (taps),
        .taps_next (taps_next),
        .exhausted (exhausted)
    );

    assign wd_hit = (wd == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        ena_c       = 1'b0;
        take_coef_c = 1'b0;
        coef_c      = '0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = WAIT_RDY;
            end
            WAIT_RDY: begin
                busy  = 1'b1;
                ena_c = 1'b1;
                if (nlfsr.ready) state_next = LOAD;
            end
            LOAD: begin
                busy        = 1'b1;
                ena_c       = 1'b1;
                take_coef_c = 1'b1;
                coef_c      = taps[k];
                if (k == K_W'(NUM_OF_TAPS - 1)) state_next = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                ena_c = 1'b1;
                if (nlfsr.found || nlfsr.failure || wd_hit) state_next = NEXT;
            end
            NEXT: begin
                busy       = 1'b1;
                ena_c      = 1'b1;
                state_next = exhausted ? DONE : WAIT_RDY;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = WAIT_RDY;
            end
            default: state_next = IDLE;
        endcase
    end

    assign nlfsr.ena       = ena_c;
    assign nlfsr.take_coef = take_coef_c;
    assign nlfsr.coef      = coef_c;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            taps        <= first_taps();
            k           <= '0;
            wd          <= '0;
            timeout_err <= 1'b0;
            found_cnt   <= '0;
            cand_cnt    <= '0;
            last_found  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        taps        <= first_taps();
                        k           <= '0;
                        wd          <= '0;
                        timeout_err <= 1'b0;
                        found_cnt   <= '0;
                        cand_cnt    <= '0;
                    end
                end
                WAIT_RDY: k <= '0;
                LOAD:     k <= k + 1'b1;
                RUN: begin
                    wd <= wd + 1'b1;
                    // found wins over failure and over a coincident expiry
                    if (nlfsr.found) begin
                        last_found <= pack_taps(taps);
                        if (found_cnt != '1) found_cnt <= found_cnt + 1'b1;
                    end else if (!nlfsr.failure && wd_hit) begin
                        timeout_err <= 1'b1;
                    end
                end
                NEXT: begin
                    wd <= '0;
                    if (cand_cnt != '1) cand_cnt <= cand_cnt + 1'b1;
                    if (!exhausted) taps <= taps_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nlfsr_tap_feeder.sv
// Directed bench: walks the full C(31,2) space with a scripted NLFSR responder.
module tb_nlfsr_tap_feeder;

    logic        clk = 1'b0;
    logic        res;
    logic        start;
    logic        busy, done, timeout_err;
    logic [15:0] found_cnt, cand_cnt;
    logic [15:0] last_found;

    int compared   = 0;
    int mismatched = 0;

    nlfsr_tap_feeder_if bus ();

    nlfsr_tap_feeder #(
        .BYTES       (4),
        .NUM_OF_TAPS (2),
        .TIMEOUT_CYC (16),
        .CNT_W       (16)
    ) dut (
        .clk         (clk),
        .res         (res),
        .start       (start),
        .nlfsr       (bus),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .found_cnt   (found_cnt),
        .cand_cnt    (cand_cnt),
        .last_found  (last_found)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: observed still running, expected finished");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_load(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (bus.take_coef === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("load_timeout", 32'(bus.take_coef), 32'd1);
    endtask

    // Returns at the negedge showing the last coefficient byte
    task automatic get_cand(output logic [7:0] a, output logic [7:0] b, output bit ok);
        a = '0;
        b = '0;
        wait_load(ok);
        if (ok) begin
            a = bus.coef;
            @(negedge clk);
            check("take_coef_2nd", 32'(bus.take_coef), 32'd1);
            b = bus.coef;
        end
    endtask

    task automatic respond(input bit f, input bit x, input int dly);
        repeat (dly) @(negedge clk);
        bus.found   = f;
        bus.failure = x;
        @(negedge clk);
        bus.found   = 1'b0;
        bus.failure = 1'b0;
    endtask

    initial begin
        logic [7:0] ca, cb;
        bit         ok;
        bit         stop;
        int         p;

        res         = 1'b1;
        start       = 1'b0;
        bus.ready   = 1'b1;
        bus.found   = 1'b0;
        bus.failure = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy",       32'(busy),          32'd0);
        check("rst_done",       32'(done),          32'd0);
        check("rst_ena",        32'(bus.ena),       32'd0);
        check("rst_take_coef",  32'(bus.take_coef), 32'd0);
        check("rst_coef",       32'(bus.coef),      32'd0);
        check("rst_timeout",    32'(timeout_err),   32'd0);
        check("rst_found_cnt",  32'(found_cnt),     32'd0);
        check("rst_cand_cnt",   32'(cand_cnt),      32'd0);
        check("rst_last_found", 32'(last_found),    32'd0);

        res = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("wait_rdy_busy",      32'(busy),          32'd1);
        check("wait_rdy_ena",       32'(bus.ena),       32'd1);
        check("wait_rdy_take_coef", 32'(bus.take_coef), 32'd0);

        stop = 1'b0;
        p    = 0;
        for (int a = 1; a <= 30; a++) begin
            for (int b = a + 1; b <= 31; b++) begin
                if (!stop) begin
                    get_cand(ca, cb, ok);
                    if (!ok) begin
                        stop = 1'b1;
                    end else begin
                        check("cand_t0", 32'(ca), 32'(a));
                        check("cand_t1", 32'(cb), 32'(b));
                        case (p)
                            0: begin
                                @(negedge clk);
                                check("load_len_take_coef", 32'(bus.take_coef), 32'd0);
                                check("run_busy",           32'(busy),          32'd1);
                                respond(1'b0, 1'b1, 1);
                            end
                            2: begin
                                respond(1'b1, 1'b0, 2);
                                @(negedge clk);
                                check("found_last_found", 32'(last_found), 32'h0104);
                                check("found_found_cnt",  32'(found_cnt),  32'd1);
                                check("found_cand_cnt",   32'(cand_cnt),   32'd3);
                            end
                            3: begin
                                respond(1'b1, 1'b1, 2);
                                check("both_found_cnt",  32'(found_cnt),  32'd2);
                                check("both_last_found", 32'(last_found), 32'h0105);
                                @(negedge clk);
                                check("both_cand_cnt",   32'(cand_cnt),   32'd4);
                            end
                            4: begin
                                repeat (16) @(negedge clk);
                                check("wd_before_expiry", 32'(timeout_err), 32'd0);
                                check("wd_before_busy",   32'(busy),        32'd1);
                                @(negedge clk);
                                check("wd_expired",       32'(timeout_err), 32'd1);
                                check("wd_found_cnt",     32'(found_cnt),   32'd2);
                                @(negedge clk);
                                check("wd_cand_cnt",      32'(cand_cnt),    32'd5);
                            end
                            default: respond(1'b0, 1'b1, 2);
                        endcase
                        p++;
                    end
                end
            end
        end

        @(negedge clk);
        check("done_flag",       32'(done),        32'd1);
        check("done_busy",       32'(busy),        32'd0);
        check("done_ena",        32'(bus.ena),     32'd0);
        check("done_cand_cnt",   32'(cand_cnt),    32'd465);
        check("done_found_cnt",  32'(found_cnt),   32'd2);
        check("done_timeout",    32'(timeout_err), 32'd1);
        check("done_last_found", 32'(last_found),  32'h0105);

        bus.found = 1'b1;
        @(negedge clk);
        bus.found = 1'b0;
        @(negedge clk);
        check("idle_verdict_found_cnt", 32'(found_cnt), 32'd2);
        check("done_sticky",            32'(done),      32'd1);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_done",       32'(done),        32'd0);
        check("restart_cand_cnt",   32'(cand_cnt),    32'd0);
        check("restart_found_cnt",  32'(found_cnt),   32'd0);
        check("restart_timeout",    32'(timeout_err), 32'd0);
        check("restart_last_found", 32'(last_found),  32'h0105);

        wait_load(ok);
        if (ok) begin
            check("restart_coef0", 32'(bus.coef), 32'd1);
            @(negedge clk);
            check("restart_coef1", 32'(bus.coef), 32'd2);
            res = 1'b1;
            #1;
            check("async_take_coef",  32'(bus.take_coef), 32'd0);
            check("async_busy",       32'(busy),          32'd0);
            check("async_ena",        32'(bus.ena),       32'd0);
            check("async_coef",       32'(bus.coef),      32'd0);
            check("async_last_found", 32'(last_found),    32'd0);
            @(negedge clk);
            res = 1'b0;
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            get_cand(ca, cb, ok);
            if (ok) begin
                check("post_res_t0", 32'(ca), 32'd1);
                check("post_res_t1", 32'(cb), 32'd2);
                respond(1'b0, 1'b1, 2);
                @(negedge clk);
                check("post_res_cand_cnt", 32'(cand_cnt), 32'd1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/nlfsr_tap_feeder.md
Name: nlfsr_tap_feeder

Overview:
Upstream stage of the NLFSR search core. It enumerates every candidate non-linear tap set in lexicographic order and shifts each set into the NLFSR one byte at a time over the take_coef/coef interface. It then waits for the NLFSR's found/failure verdict, records successful tap sets, and moves on to the next candidate until the space is exhausted. A watchdog converts a missing verdict into a failure.

Parameters:
BYTES, 4, register length in bytes; MAX_TAP = BYTES*8-1
NUM_OF_TAPS, 2, taps per candidate (one coef byte each)
TIMEOUT_CYC, 4096, max cycles in RUN before forced failure
CNT_W, 16, width of found/candidate counters

Ports:
clk  in  1  system clock
res  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins enumeration from the first candidate
ready  in  1  NLFSR idle/able to accept coefficients
failure  in  1  NLFSR verdict: candidate rejected (1-cycle pulse)
found  in  1  NLFSR verdict: candidate accepted (1-cycle pulse)
ena  out  1  enable to NLFSR; high whenever not IDLE/DONE
take_coef  out  1  coef-valid strobe to NLFSR
coef  out  8  tap index being loaded
busy  out  1  enumeration in progress
done  out  1  sticky; space exhausted
timeout_err  out  1  sticky; at least one watchdog expiry
found_cnt  out  CNT_W  number of accepted candidates (saturating)
cand_cnt  out  CNT_W  number of verdicts processed (saturating)
last_found  out  NUM_OF_TAPS*8  most recent accepted tap set; tap[0] in MSB byte

Behaviour:
- Reset: state IDLE; all outputs 0; taps t[i]=i+1; watchdog 0.
- Candidate: t[0]<t[1]<...<t[N-1], each t[i] in 1..MAX_TAP. First candidate is (1,2,...,N). Last is (MAX_TAP-N+1,...,MAX_TAP).
- States:
  - IDLE: on start, clear done, timeout_err and counters, reset taps, go to WAIT_RDY.
  - WAIT_RDY: stay until ready=1, then go to LOAD with k=0.
  - LOAD: take_coef=1, coef=t[k] for exactly NUM_OF_TAPS consecutive cycles (k=0..N-1); take_coef=0 at all other times. After the last byte, go to RUN.
  - RUN: watchdog increments each cycle.
    - found: last_found<={t[0],...,t[N-1]}, found_cnt++, go to NEXT.
    - failure: go to NEXT.
    - Both in the same cycle: treated as found.
    - Watchdog reaching TIMEOUT_CYC-1 with no verdict: set timeout_err, treat as failure.
    - Verdicts outside RUN are ignored.
  - NEXT (1 cycle): cand_cnt++; watchdog cleared; advance the combination. Find the rightmost i with t[i] < MAX_TAP-(N-1-i); increment t[i]; set t[j]=t[j-1]+1 for j>i. If no such i: go to DONE, else go to WAIT_RDY.
  - DONE: done=1, busy=0, ena=0; start restarts the enumeration as from IDLE.
- busy=1 in WAIT_RDY, LOAD, RUN and NEXT. start is ignored while busy.
- Counters saturate at all-ones.
- res asserted mid-LOAD or mid-RUN: take_coef drops immediately (async), everything returns to reset values.
- Latency from start (ready=1) to first take_coef: 2 cycles (IDLE→WAIT_RDY→LOAD).

Decomposition:
- Shared package nlfsr_pkg: state enum (IDLE, WAIT_RDY, LOAD, RUN, NEXT, DONE), MAX_TAP function of BYTES, coef width 8.
- One sub-module, nlfsr_comb_next: combinational next-combination plus exhausted flag over NUM_OF_TAPS tap registers. The FSM, counters and watchdog stay in the top module.

Test Plan:
1. BYTES=4, N=2, ready=1, start pulse -> two take_coef cycles, coef=0x01 then 0x02; busy=1; ena=1.
2. BFM always answers failure 3 cycles after the last take_coef -> candidate after (1,31) is (2,3); done=1 after cand_cnt=465 (C(31,2)); found_cnt=0; last candidate (30,31).
3. BFM answers found on the 3rd candidate (1,4) only -> last_found=16'h0104, found_cnt=1; enumeration continues to (1,5).
4. found and failure asserted together in RUN -> counted as found (found_cnt increments); single NEXT step.
5. BFM silent, TIMEOUT_CYC=16 -> after 16 RUN cycles timeout_err=1, cand_cnt=1, next candidate loaded.
6. res pulsed during the 2nd LOAD cycle -> take_coef=0 and state IDLE in the same cycle; outputs 0; new start begins again at (1,2).
